reg_exec_ctrl: RTL and testbench

//  Execute/write-back sequencer sitting directly around the 8x16 register file (2 read ports, 1 write port).

---
 rtl/reg_exec_ctrl_pkg.sv | 43 ++++
 rtl/reg_exec_ctrl_alu.sv | 51 +++++
 rtl/reg_exec_ctrl.sv | 158 +++++++++++++++
 tb/tb_reg_exec_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_exec_ctrl_pkg.sv
// Shared definitions for the execute/write-back sequencer: opcodes, FSM states,
// instruction field positions and small opcode classification helpers.
package reg_exec_ctrl_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_NOT = 4'h6;
  localparam logic [3:0] OP_SHL = 4'h7;
  localparam logic [3:0] OP_SHR = 4'h8;
  localparam logic [3:0] OP_LDI = 4'h9;
  localparam logic [3:0] OP_MOV = 4'hA;
  localparam logic [3:0] OP_CMP = 4'hB;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  localparam int OP_LSB  = 12;
  localparam int RD_LSB  = 9;
  localparam int RA_LSB  = 6;
  localparam int RB_LSB  = 3;
  localparam int IMM_LSB = 0;

  // Opcodes C-F are undefined and retire as illegal.
  function automatic logic op_legal(input logic [3:0] op);
    return op <= OP_CMP;
  endfunction

  function automatic logic op_writes(input logic [3:0] op);
    return op_legal(op) && (op != OP_NOP) && (op != OP_CMP);
  endfunction

  function automatic logic op_sets_flags(input logic [3:0] op);
    return op_legal(op) && (op != OP_NOP);
  endfunction

endpackage

// File: rtl/reg_exec_ctrl_alu.sv
// Combinational 16-bit ALU used in the EXEC cycle; c carries carry/borrow/shifted-out bit.
module alu16
  import reg_exec_ctrl_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic [3:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [7:0]    imm8,
  output logic [DW-1:0] result,
  output logic          c
);

  logic [DW:0] sum;
  logic [DW:0] diff;

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    // Top bit of the widened difference is the unsigned borrow (a < b).
    diff   = {1'b0, a} - {1'b0, b};
    result = '0;
    c      = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum[DW-1:0];
        c      = sum[DW];
      end
      OP_SUB, OP_CMP: begin
        result = diff[DW-1:0];
        c      = diff[DW];
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOT: result = ~a;
      OP_SHL: begin
        result = {a[DW-2:0], 1'b0};
        c      = a[DW-1];
      end
      OP_SHR: begin
        result = {1'b0, a[DW-1:1]};
        c      = a[0];
      end
      OP_LDI: result = {{(DW-8){1'b0}}, imm8};
      OP_MOV: result = a;
      default: ;
    endcase
  end

endmodule

// File: rtl/reg_exec_ctrl.sv
// Non-pipelined execute/write-back sequencer around an 8x16 register file.
// One instruction in flight: IDLE (accept) -> EXEC (read, compute) -> WB (write, retire).
module reg_exec_ctrl
  import reg_exec_ctrl_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 3,
  parameter int IW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          instr_valid,
  input  logic [IW-1:0] instr,
  output logic          instr_ready,
  output logic [AW-1:0] rd_addr_a,
  output logic [AW-1:0] rd_addr_b,
  input  logic [DW-1:0] d_out_a,
  input  logic [DW-1:0] d_out_b,
  output logic          wr,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] d_in,
  output logic          done,
  output logic          illegal,
  output logic          flag_z,
  output logic          flag_c,
  output logic          flag_n
);

  state_e        state_q, state_d;
  logic [IW-1:0] instr_q, instr_d;
  logic          ready_q, ready_d;
  logic [AW-1:0] rd_addr_a_q, rd_addr_a_d;
  logic [AW-1:0] rd_addr_b_q, rd_addr_b_d;
  logic          wr_q, wr_d;
  logic          done_q, done_d;
  logic          illegal_q, illegal_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] d_in_q, d_in_d;
  logic          flag_z_q, flag_z_d;
  logic          flag_c_q, flag_c_d;
  logic          flag_n_q, flag_n_d;

  logic [3:0]    op;
  logic [DW-1:0] alu_result;
  logic          alu_c;

  assign op = instr_q[OP_LSB +: 4];

  alu16 #(.DW(DW)) u_alu (
    .op     (op),
    .a      (d_out_a),
    .b      (d_out_b),
    .imm8   (instr_q[IMM_LSB +: 8]),
    .result (alu_result),
    .c      (alu_c)
  );

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    ready_d     = ready_q;
    rd_addr_a_d = rd_addr_a_q;
    rd_addr_b_d = rd_addr_b_q;
    wr_d        = wr_q;
    done_d      = done_q;
    illegal_d   = illegal_q;
    wr_addr_d   = wr_addr_q;
    d_in_d      = d_in_q;
    flag_z_d    = flag_z_q;
    flag_c_d    = flag_c_q;
    flag_n_d    = flag_n_q;
    case (state_q)
      ST_IDLE: begin
        // Read addresses are loaded at accept so they are valid throughout EXEC.
        if (instr_valid && ready_q) begin
          instr_d     = instr;
          rd_addr_a_d = instr[RA_LSB +: AW];
          rd_addr_b_d = instr[RB_LSB +: AW];
          ready_d     = 1'b0;
          state_d     = ST_EXEC;
        end
      end
      ST_EXEC: begin
        wr_d      = op_writes(op);
        done_d    = op_legal(op);
        illegal_d = ~op_legal(op);
        wr_addr_d = instr_q[RD_LSB +: AW];
        d_in_d    = alu_result;
        if (op_sets_flags(op)) begin
          flag_z_d = (alu_result == '0);
          flag_c_d = alu_c;
          flag_n_d = alu_result[DW-1];
        end
        state_d = ST_WB;
      end
      ST_WB: begin
        wr_d      = 1'b0;
        done_d    = 1'b0;
        illegal_d = 1'b0;
        ready_d   = 1'b1;
        state_d   = ST_IDLE;
      end
      default: begin
        wr_d      = 1'b0;
        done_d    = 1'b0;
        illegal_d = 1'b0;
        ready_d   = 1'b1;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      instr_q     <= '0;
      ready_q     <= 1'b1;
      rd_addr_a_q <= '0;
      rd_addr_b_q <= '0;
      wr_q        <= 1'b0;
      done_q      <= 1'b0;
      illegal_q   <= 1'b0;
      wr_addr_q   <= '0;
      d_in_q      <= '0;
      flag_z_q    <= 1'b0;
      flag_c_q    <= 1'b0;
      flag_n_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      ready_q     <= ready_d;
      rd_addr_a_q <= rd_addr_a_d;
      rd_addr_b_q <= rd_addr_b_d;
      wr_q        <= wr_d;
      done_q      <= done_d;
      illegal_q   <= illegal_d;
      wr_addr_q   <= wr_addr_d;
      d_in_q      <= d_in_d;
      flag_z_q    <= flag_z_d;
      flag_c_q    <= flag_c_d;
      flag_n_q    <= flag_n_d;
    end
  end

  // Reset during WB must stop the register file from latching the pending write.
  assign wr          = wr_q & ~reset;
  assign done        = done_q & ~reset;
  assign illegal     = illegal_q & ~reset;
  assign instr_ready = ready_q;
  assign rd_addr_a   = rd_addr_a_q;
  assign rd_addr_b   = rd_addr_b_q;
  assign wr_addr     = wr_addr_q;
  assign d_in        = d_in_q;
  assign flag_z      = flag_z_q;
  assign flag_c      = flag_c_q;
  assign flag_n      = flag_n_q;

endmodule

// File: tb/tb_reg_exec_ctrl.sv
// Bench for reg_exec_ctrl: directed vector table, reset corner cases, a held-valid
// dependency chain and randomized instructions checked against an arithmetic model.
module tb_reg_exec_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [2:0]  rd_addr_a, rd_addr_b;
  logic [15:0] d_out_a, d_out_b;
  logic        wr;
  logic [2:0]  wr_addr;
  logic [15:0] d_in;
  logic        done, illegal, flag_z, flag_c, flag_n;

  always #5 clk = ~clk;

  reg_exec_ctrl dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .d_out_a(d_out_a), .d_out_b(d_out_b), .wr(wr), .wr_addr(wr_addr), .d_in(d_in),
    .done(done), .illegal(illegal), .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n)
  );

  // Register file the block drives.
  logic [15:0] rf [8] = '{default: 16'h0000};
  always @(posedge clk) if (wr) rf[wr_addr] <= d_in;
  assign d_out_a = rf[rd_addr_a];
  assign d_out_b = rf[rd_addr_b];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    bit          wr, done, ill;
    logic [2:0]  wa;
    logic [15:0] d;
    bit          z, c, n;
    int          cyc;
  } obs_t;

  typedef struct {
    logic [15:0] ins;
    obs_t        exp;
  } vec_t;

  // Reference model state: eight registers and the three flags.
  int m_rf [8] = '{default: 0};
  bit m_z = 0, m_c = 0, m_n = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] enc(input int op, input int rd, input int ra, input int rb);
    logic [3:0] o; logic [2:0] d, a, b;
    o = 4'(op); d = 3'(rd); a = 3'(ra); b = 3'(rb);
    return {o, d, a, b, 3'b000};
  endfunction

  function automatic logic [15:0] ldi(input int rd, input int imm);
    logic [2:0] d; logic [7:0] i;
    d = 3'(rd); i = 8'(imm);
    return {4'h9, d, 1'b0, i};
  endfunction

  function automatic obs_t mk(input bit w, input bit dn, input bit il, input int wa,
                              input int d, input bit z, input bit c, input bit n);
    obs_t o;
    o.wr = w; o.done = dn; o.ill = il; o.wa = 3'(wa); o.d = 16'(d);
    o.z = z; o.c = c; o.n = n; o.cyc = 0;
    return o;
  endfunction

  // Executes one instruction on the model with plain integer arithmetic.
  function automatic obs_t model(input logic [15:0] ins);
    obs_t e;
    int op, a, b, r, wa;
    bit c, wrt, fl;
    op = int'(ins[15:12]);
    wa = int'(ins[11:9]);
    a  = m_rf[ins[8:6]];
    b  = m_rf[ins[5:3]];
    r = 0; c = 0; wrt = 1; fl = 1;
    case (op)
      0:  begin wrt = 0; fl = 0; end
      1:  begin r = a + b; c = (r > 65535); end
      2, 11: begin r = a - b; c = (a < b); if (r < 0) r += 65536; if (op == 11) wrt = 0; end
      3:  r = a & b;
      4:  r = a | b;
      5:  r = a ^ b;
      6:  r = 65535 - a;
      7:  begin r = a * 2; c = (a >= 32768); end
      8:  begin r = a / 2; c = (a % 2 == 1); end
      9:  r = int'(ins[7:0]);
      10: r = a;
      default: begin wrt = 0; fl = 0; end
    endcase
    r = r % 65536;
    if (fl) begin m_z = (r == 0); m_c = c; m_n = (r >= 32768); end
    if (wrt) m_rf[wa] = r;
    e = mk(wrt, op < 12, op >= 12, wa, r, m_z, m_c, m_n);
    return e;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!instr_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) begin
      n_checks++; n_errors++;
      $display("FAIL accept_timeout: instr_ready stuck at 0 after %0d cycles", n);
    end
  endtask

  // Issues one instruction; returns at the negedge inside its WB cycle.
  task automatic issue(input logic [15:0] ins, input bit keep, output obs_t o, output obs_t e);
    wait_ready();
    chk("idle_wr_low", 32'(wr), 32'(1'b0));
    instr = ins;
    instr_valid = 1'b1;
    @(negedge clk);
    if (!keep) instr_valid = 1'b0;
    chk("exec_ready_low", 32'(instr_ready), 32'(1'b0));
    chk("exec_wr_low", 32'(wr), 32'(1'b0));
    chk("exec_done_low", 32'(done | illegal), 32'(1'b0));
    chk("exec_rd_addr_a", 32'(rd_addr_a), 32'(ins[8:6]));
    chk("exec_rd_addr_b", 32'(rd_addr_b), 32'(ins[5:3]));
    @(negedge clk);
    o = mk(wr, done, illegal, int'(wr_addr), int'(d_in), flag_z, flag_c, flag_n);
    o.cyc = cyc;
    e = model(ins);
  endtask

  task automatic cmp_obs(input string tag, input obs_t o, input obs_t e);
    chk({tag, "_wr"}, 32'(o.wr), 32'(e.wr));
    chk({tag, "_done"}, 32'(o.done), 32'(e.done));
    chk({tag, "_illegal"}, 32'(o.ill), 32'(e.ill));
    if (e.wr) begin
      chk({tag, "_wr_addr"}, 32'(o.wa), 32'(e.wa));
      chk({tag, "_d_in"}, 32'(o.d), 32'(e.d));
    end
    chk({tag, "_flags"}, 32'({o.z, o.c, o.n}), 32'({e.z, e.c, e.n}));
  endtask

  vec_t vt [13];
  obs_t o, e;
  int   prev_cyc;

  initial begin
    // Directed table: regs start at zero; flags listed as z,c,n after each instruction.
    vt[0]  = '{ldi(1, 8'h34),     mk(1, 1, 0, 1, 16'h0034, 0, 0, 0)};
    vt[1]  = '{ldi(2, 8'hFF),     mk(1, 1, 0, 2, 16'h00FF, 0, 0, 0)};
    vt[2]  = '{ldi(1, 8'h00),     mk(1, 1, 0, 1, 16'h0000, 1, 0, 0)};
    vt[3]  = '{enc(6, 1, 1, 0),   mk(1, 1, 0, 1, 16'hFFFF, 0, 0, 1)};
    vt[4]  = '{ldi(2, 8'h01),     mk(1, 1, 0, 2, 16'h0001, 0, 0, 0)};
    vt[5]  = '{enc(1, 3, 1, 2),   mk(1, 1, 0, 3, 16'h0000, 1, 1, 0)};
    vt[6]  = '{enc(2, 4, 2, 1),   mk(1, 1, 0, 4, 16'h0002, 0, 1, 0)};
    vt[7]  = '{enc(11, 0, 1, 1),  mk(0, 1, 0, 0, 0,        1, 0, 0)};
    vt[8]  = '{enc(14, 5, 1, 2),  mk(0, 0, 1, 0, 0,        1, 0, 0)};
    vt[9]  = '{enc(0, 6, 1, 2),   mk(0, 1, 0, 0, 0,        1, 0, 0)};
    vt[10] = '{enc(10, 7, 4, 0),  mk(1, 1, 0, 7, 16'h0002, 0, 0, 0)};
    vt[11] = '{enc(3, 0, 1, 2),   mk(1, 1, 0, 0, 16'h0001, 0, 0, 0)};
    vt[12] = '{enc(8, 6, 1, 0),   mk(1, 1, 0, 6, 16'h7FFF, 0, 1, 0)};

    reset = 1'b1; instr_valid = 1'b0; instr = 16'h0000;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_ready", 32'(instr_ready), 32'(1'b1));
    chk("rst_wr_done_ill", 32'({wr, done, illegal}), 32'(3'b000));
    chk("rst_flags", 32'({flag_z, flag_c, flag_n}), 32'(3'b000));
    chk("rst_wr_addr_d_in", 32'({wr_addr, d_in}), 32'(0));
    chk("rst_rd_addr", 32'({rd_addr_a, rd_addr_b}), 32'(0));

    prev_cyc = 0;
    for (int i = 0; i < 13; i++) begin
      issue(vt[i].ins, 1'b0, o, e);
      cmp_obs($sformatf("vec%0d", i), o, vt[i].exp);
      if (i > 0) chk("done_spacing", 32'(o.cyc - prev_cyc), 32'(3));
      prev_cyc = o.cyc;
    end

    // Reset during the WB cycle of ADD r1=r1+r2 (r1=FFFF, r2=0001): write is dropped.
    wait_ready();
    instr = enc(1, 1, 1, 2); instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("rst_wb_pending_wr", 32'(wr), 32'(1'b1));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_wb_wr_low", 32'(wr), 32'(1'b0));
    chk("rst_wb_ready", 32'(instr_ready), 32'(1'b1));
    chk("rst_wb_flags", 32'({flag_z, flag_c, flag_n}), 32'(3'b000));
    chk("rst_wb_r1_kept", 32'(rf[1]), 32'h0000FFFF);
    m_z = 0; m_c = 0; m_n = 0;

    // Reset coincident with a handshake: the instruction must not be accepted.
    instr = enc(1, 2, 2, 2); instr_valid = 1'b1; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; instr_valid = 1'b0;
    chk("rst_beats_hs_ready", 32'(instr_ready), 32'(1'b1));
    repeat (2) begin
      @(negedge clk);
      chk("rst_beats_hs_no_retire", 32'({wr, done, illegal}), 32'(3'b000));
    end

    // Dependency chain with valid held high: LDI r5,0x80 then SHL r5 nine times.
    issue(ldi(5, 8'h80), 1'b1, o, e);
    cmp_obs("chain_ldi", o, e);
    prev_cyc = o.cyc;
    for (int k = 1; k <= 9; k++) begin
      issue(enc(7, 5, 5, 0), 1'b1, o, e);
      cmp_obs($sformatf("chain_shl%0d", k), o, e);
      chk("chain_spacing", 32'(o.cyc - prev_cyc), 32'(3));
      prev_cyc = o.cyc;
      if (k == 8) begin
        chk("chain_shl8_d_in", 32'(o.d), 32'h00008000);
        chk("chain_shl8_flags", 32'({o.z, o.c, o.n}), 32'(3'b001));
      end
      if (k == 9) begin
        chk("chain_shl9_d_in", 32'(o.d), 32'h00000000);
        chk("chain_shl9_flags", 32'({o.z, o.c, o.n}), 32'(3'b110));
      end
    end
    instr_valid = 1'b0;

    // Random instructions with randomly toggled instr_valid.
    for (int k = 0; k < 200; k++) begin
      int idle;
      logic [15:0] ri;
      idle = int'($urandom_range(0, 2));
      ri = 16'($urandom());
      instr_valid = 1'b0;
      repeat (idle) begin
        @(negedge clk);
        instr = 16'($urandom());
      end
      issue(ri, 1'($urandom_range(0, 1)), o, e);
      cmp_obs("rand", o, e);
    end
    instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    for (int r = 0; r < 8; r++)
      chk($sformatf("final_r%0d", r), 32'(rf[r]), 32'(m_rf[r]));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
